// File: rtl/mem_write_arbiter_pkg.sv
// Shared types and MCB command constants for the two-port memory write arbiter.
package mem_write_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_CMD
  } state_e;

  localparam logic [2:0] MCB_INSTR_WRITE = 3'b000;
  localparam logic [5:0] MCB_BL_SINGLE   = 6'd0;

endpackage

// File: rtl/mem_write_arbiter_rr_arbiter2.sv
// Two-way combinational arbiter: last_ptr names the requester served most recently,
// so on a tie the other one wins.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_ptr,
  output logic [1:0] grant
);

  assign grant[0] = req[0] & (~req[1] | last_ptr);
  assign grant[1] = req[1] & (~req[0] | ~last_ptr);

endmodule

// File: rtl/mem_write_arbiter.sv
// Arbitrates two single-word write requesters onto an MCB write/command port pair.
// Define MEM_ARB_FIXED_PRIO_EN to give requester 0 fixed priority instead of round-robin.
module mem_write_arbiter
  import mem_write_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 30,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    req_0,
  input  logic [ADDR_WIDTH-1:0]   addr_0,
  input  logic [DATA_WIDTH-1:0]   data_0,
  input  logic [DATA_WIDTH/8-1:0] mask_0,
  output logic                    done_0,

  input  logic                    req_1,
  input  logic [ADDR_WIDTH-1:0]   addr_1,
  input  logic [DATA_WIDTH-1:0]   data_1,
  input  logic [DATA_WIDTH/8-1:0] mask_1,
  output logic                    done_1,

  output logic                    mem_wr_en,
  output logic [DATA_WIDTH-1:0]   mem_wr_data,
  output logic [DATA_WIDTH/8-1:0] mem_wr_mask,
  input  logic                    mem_wr_full,

  output logic                    mem_cmd_en,
  output logic [2:0]              mem_cmd_instr,
  output logic [5:0]              mem_cmd_bl,
  output logic [ADDR_WIDTH-1:0]   mem_cmd_byte_addr,
  input  logic                    mem_cmd_full
);

  localparam int MASK_WIDTH = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ALIGN_MASK = ~ADDR_WIDTH'(3);

  state_e                  state_q, state_d;
  logic                    gnt_q, gnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [MASK_WIDTH-1:0]   mask_q, mask_d;
  logic [1:0]              grant;
  logic                    arb_ptr;

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign arb_ptr = 1'b1;
`else
  logic ptr_q, ptr_d;
  assign arb_ptr = ptr_q;
`endif

  rr_arbiter2 u_arb (
    .req      ({req_1, req_0}),
    .last_ptr (arb_ptr),
    .grant    (grant)
  );

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    mask_d     = mask_q;
    mem_wr_en  = 1'b0;
    mem_cmd_en = 1'b0;
    done_0     = 1'b0;
    done_1     = 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
    ptr_d      = ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          gnt_d   = grant[1];
          addr_d  = grant[1] ? addr_1 : addr_0;
          data_d  = grant[1] ? data_1 : data_0;
          mask_d  = grant[1] ? mask_1 : mask_0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (!mem_wr_full) begin
          mem_wr_en = 1'b1;
          state_d   = ST_CMD;
        end
      end
      ST_CMD: begin
        if (!mem_cmd_full) begin
          mem_cmd_en = 1'b1;
          done_0     = ~gnt_q;
          done_1     = gnt_q;
`ifndef MEM_ARB_FIXED_PRIO_EN
          ptr_d      = gnt_q;
`endif
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pointer resets to 1 so that requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      mask_q  <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      ptr_q   <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign mem_wr_data       = data_q;
  assign mem_wr_mask       = mask_q;
  assign mem_cmd_instr     = MCB_INSTR_WRITE;
  assign mem_cmd_bl        = MCB_BL_SINGLE;
  assign mem_cmd_byte_addr = addr_q & ADDR_ALIGN_MASK;

endmodule

// File: tb/tb_mem_write_arbiter.sv
// Scoreboard bench for mem_write_arbiter: stimulus queues expected MCB pushes with
// their cycle numbers, a negedge monitor pops and compares them.
module tb_mem_write_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_0 = 1'b0, req_1 = 1'b0;
  logic [29:0] addr_0 = '0, addr_1 = '0;
  logic [31:0] data_0 = '0, data_1 = '0;
  logic [3:0]  mask_0 = '0, mask_1 = '0;
  logic        done_0, done_1;
  logic        mem_wr_en, mem_cmd_en;
  logic [31:0] mem_wr_data;
  logic [3:0]  mem_wr_mask;
  logic        mem_wr_full = 1'b0, mem_cmd_full = 1'b0;
  logic [2:0]  mem_cmd_instr;
  logic [5:0]  mem_cmd_bl;
  logic [29:0] mem_cmd_byte_addr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    bit          is_cmd;
    int          cyc;
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    int          who;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  mem_write_arbiter #(.ADDR_WIDTH(30), .DATA_WIDTH(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .req_0             (req_0),
    .addr_0            (addr_0),
    .data_0            (data_0),
    .mask_0            (mask_0),
    .done_0            (done_0),
    .req_1             (req_1),
    .addr_1            (addr_1),
    .data_1            (data_1),
    .mask_1            (mask_1),
    .done_1            (done_1),
    .mem_wr_en         (mem_wr_en),
    .mem_wr_data       (mem_wr_data),
    .mem_wr_mask       (mem_wr_mask),
    .mem_wr_full       (mem_wr_full),
    .mem_cmd_en        (mem_cmd_en),
    .mem_cmd_instr     (mem_cmd_instr),
    .mem_cmd_bl        (mem_cmd_bl),
    .mem_cmd_byte_addr (mem_cmd_byte_addr),
    .mem_cmd_full      (mem_cmd_full)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic expWr(input int c, input logic [31:0] d, input logic [3:0] m);
    exp_t e;
    e.is_cmd = 1'b0; e.cyc = c; e.addr = '0; e.data = d; e.mask = m; e.who = 0;
    exp_q.push_back(e);
  endtask

  task automatic expCmd(input int c, input logic [29:0] a, input int who);
    exp_t e;
    e.is_cmd = 1'b1; e.cyc = c; e.addr = a; e.data = '0; e.mask = '0; e.who = who;
    exp_q.push_back(e);
  endtask

  // Raise one requester, hold until its done pulse, drop right after that edge.
  task automatic applyStimulus(input int sel, input logic [29:0] a, input logic [31:0] d, input logic [3:0] m);
    bit got = 1'b0;
    if (sel == 0) begin req_0 = 1'b1; addr_0 = a; data_0 = d; mask_0 = m; end
    else          begin req_1 = 1'b1; addr_1 = a; data_1 = d; mask_1 = m; end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ((sel == 0) ? done_0 : done_1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout_%0d: got no done, expected done within 100 cycles", sel);
    end
    @(posedge clk);
    #1;
    if (sel == 0) req_0 = 1'b0; else req_1 = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_wr_en",   {63'd0, mem_wr_en},  64'd0);
    checkOutput("rst_cmd_en",  {63'd0, mem_cmd_en}, 64'd0);
    checkOutput("rst_done",    {62'd0, done_1, done_0}, 64'd0);
    checkOutput("rst_wr_data", {32'd0, mem_wr_data}, 64'd0);
    checkOutput("rst_addr",    {34'd0, mem_cmd_byte_addr}, 64'd0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_wr_en) begin
        if (exp_q.size() == 0 || exp_q[0].is_cmd) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_wr: got wr_en=1 data 0x%0h, expected no write (cycle %0d)", mem_wr_data, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("wr_cycle", 64'(cyc), 64'(mon_e.cyc));
          checkOutput("wr_data",  {32'd0, mem_wr_data}, {32'd0, mon_e.data});
          checkOutput("wr_mask",  {60'd0, mem_wr_mask}, {60'd0, mon_e.mask});
        end
      end
      if (mem_cmd_en) begin
        if (exp_q.size() == 0 || !exp_q[0].is_cmd) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_cmd: got cmd_en=1 addr 0x%0h, expected no command (cycle %0d)", mem_cmd_byte_addr, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("cmd_cycle", 64'(cyc), 64'(mon_e.cyc));
          checkOutput("cmd_addr",  {34'd0, mem_cmd_byte_addr}, {34'd0, mon_e.addr});
          checkOutput("cmd_instr", {61'd0, mem_cmd_instr}, 64'd0);
          checkOutput("cmd_bl",    {58'd0, mem_cmd_bl}, 64'd0);
          checkOutput("cmd_done",  {62'd0, done_1, done_0}, (mon_e.who == 0) ? 64'd1 : 64'd2);
        end
      end
      if ((done_0 || done_1) && !mem_cmd_en) begin
        checks++; errors++;
        $display("[TB] FAIL stray_done: got done=%b%b without cmd_en (cycle %0d)", done_1, done_0, cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no end of test, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c;
    doReset();

    // Single write: latency 1 to wr_en, 2 to cmd/done.
    @(posedge clk); #1 c = cyc;
    expWr(c + 1, 32'hDEADBEEF, 4'h0);
    expCmd(c + 2, 30'h100, 0);
    applyStimulus(0, 30'h100, 32'hDEADBEEF, 4'h0);

    // Requester 0 served last, so a tie goes to requester 1.
    @(posedge clk); #1 c = cyc;
    expWr(c + 1, 32'h22222222, 4'h2);
    expCmd(c + 2, 30'h300, 1);
    expWr(c + 4, 32'h11111111, 4'h1);
    expCmd(c + 5, 30'h200, 0);
    fork
      applyStimulus(0, 30'h200, 32'h11111111, 4'h1);
      applyStimulus(1, 30'h300, 32'h22222222, 4'h2);
    join

    // Tie right after reset: requester 0 first, requester 1 done at cycle 5.
    doReset();
    @(posedge clk); #1 c = cyc;
    expWr(c + 1, 32'hAAAA0000, 4'h0);
    expCmd(c + 2, 30'h040, 0);
    expWr(c + 4, 32'hBBBB1111, 4'hC);
    expCmd(c + 5, 30'h080, 1);
    fork
      applyStimulus(0, 30'h040, 32'hAAAA0000, 4'h0);
      applyStimulus(1, 30'h080, 32'hBBBB1111, 4'hC);
    join

    // Write FIFO full for 5 cycles in DATA while requester inputs keep changing.
    @(posedge clk); #1 c = cyc;
    mem_wr_full = 1'b1;
    expWr(c + 6, 32'hCAFEF00D, 4'h3);
    expCmd(c + 7, 30'h400, 0);
    fork
      applyStimulus(0, 30'h400, 32'hCAFEF00D, 4'h3);
      begin
        @(posedge clk); #1;
        data_0 = 32'h12345678; addr_0 = 30'h7FC; mask_0 = 4'hF;
        repeat (5) @(posedge clk);
        #1 mem_wr_full = 1'b0;
      end
    join

    // Command FIFO full for 3 cycles in CMD; unaligned address is cleared to word.
    @(posedge clk); #1 c = cyc;
    expWr(c + 1, 32'h0BADCAFE, 4'h8);
    expCmd(c + 5, 30'h100, 1);
    fork
      applyStimulus(1, 30'h103, 32'h0BADCAFE, 4'h8);
      begin
        @(posedge clk); #1 mem_cmd_full = 1'b1;
        repeat (4) @(posedge clk);
        #1 mem_cmd_full = 1'b0;
      end
    join

    // Leave requester 0 as last served before the abandoned transaction.
    @(posedge clk); #1 c = cyc;
    expWr(c + 1, 32'h55AA55AA, 4'h0);
    expCmd(c + 2, 30'h500, 0);
    applyStimulus(0, 30'h500, 32'h55AA55AA, 4'h0);

    // Reset while stalled in CMD: no command, no done, pointer back to 1.
    @(posedge clk); #1 c = cyc;
    expWr(c + 1, 32'h66666666, 4'h5);
    req_0 = 1'b1; addr_0 = 30'h600; data_0 = 32'h66666666; mask_0 = 4'h5;
    @(posedge clk); #1 mem_cmd_full = 1'b1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; req_0 = 1'b0; mem_cmd_full = 1'b0;
    @(negedge clk);
    checkOutput("abort_cmd_en",  {63'd0, mem_cmd_en}, 64'd0);
    checkOutput("abort_done",    {62'd0, done_1, done_0}, 64'd0);
    checkOutput("abort_wr_en",   {63'd0, mem_wr_en}, 64'd0);
    checkOutput("abort_wr_data", {32'd0, mem_wr_data}, 64'd0);

    @(posedge clk); #1 c = cyc;
    expWr(c + 1, 32'h77777777, 4'h6);
    expCmd(c + 2, 30'h700, 0);
    expWr(c + 4, 32'h88888888, 4'h9);
    expCmd(c + 5, 30'h800, 1);
    fork
      applyStimulus(0, 30'h700, 32'h77777777, 4'h6);
      applyStimulus(1, 30'h800, 32'h88888888, 4'h9);
    join

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_write_arbiter.md
MEM_WRITE_ARBITER -- requirements
Module: mem_write_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 30, memory byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, memory word width; mask width is DATA_WIDTH/8.
REQ-003 clk  input  1  system clock; one clock domain; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_0  input  1  requester 0 (pixel writer) write request, held until done_0.
REQ-006 addr_0 / data_0 / mask_0  input  ADDR_WIDTH / DATA_WIDTH / 4  requester 0 byte address, word, byte mask (1 = byte not written).
REQ-007 done_0  output  1  one-cycle pulse when requester 0's command is issued.
REQ-008 req_1, addr_1, data_1, mask_1, done_1  SHALL have the same widths and meaning for requester 1 (processor data writes).
REQ-009 mem_wr_en / mem_wr_data / mem_wr_mask  output  1 / DATA_WIDTH / 4  MCB write-FIFO push, word and mask.
REQ-010 mem_wr_full  input  1  MCB write FIFO full.
REQ-011 mem_cmd_en / mem_cmd_instr / mem_cmd_bl / mem_cmd_byte_addr  output  1 / 3 / 6 / ADDR_WIDTH  MCB command push.
REQ-012 mem_cmd_full  input  1  MCB command FIFO full.

Function
REQ-013 SHALL be a 3-state FSM: IDLE, DATA, CMD.
REQ-014 IDLE: if any req is high, SHALL grant one requester, latch its addr/data/mask, and move to DATA next cycle; else stay in IDLE.
REQ-015 Arbitration SHALL be round-robin: when both requests are high, grant the requester not served last; a single request is granted immediately.
REQ-016 DATA: mem_wr_en SHALL be (state==DATA && !mem_wr_full), combinational; on a push, move to CMD.
REQ-017 CMD: mem_cmd_en SHALL be (state==CMD && !mem_cmd_full); on a push, the granted done_x SHALL pulse in the same cycle, the round-robin pointer SHALL update to that requester, and the FSM SHALL return to IDLE.
REQ-018 mem_cmd_instr SHALL be constant 3'b000 (write); mem_cmd_bl SHALL be constant 6'd0 (single word).
REQ-019 mem_cmd_byte_addr SHALL be the latched address with bits [1:0] forced to 0.
REQ-020 mem_wr_data, mem_wr_mask and mem_cmd_byte_addr SHALL come from the latched registers only; requester inputs changing after the grant SHALL have no effect.
REQ-021 Minimum latency SHALL be: request at cycle 0, wr_en at cycle 1, cmd_en and done at cycle 2, next grant decision at cycle 3; peak rate is one write per 3 cycles.
REQ-022 Full flags SHALL stall indefinitely with no timeout; the FSM SHALL hold its state and latched payload while stalled.
REQ-023 A request dropped before it is granted SHALL be ignored; a request dropped after the grant SHALL still complete.
REQ-024 A requester SHALL never receive done without a matching grant, and done_0 and done_1 SHALL never be high in the same cycle.

Reset
REQ-025 On rst: state=IDLE; pointer=1, so requester 0 wins the first tie; latched registers=0; all enables and done outputs=0 from the cycle after rst is sampled.
REQ-026 rst during DATA or CMD SHALL abandon the transaction with no done. A word already pushed in that case is orphaned; the system resets the MCB together with this block.

Configuration
REQ-027 Macro MEM_ARB_FIXED_PRIO_EN: when defined, requester 0 SHALL always win ties and the round-robin pointer SHALL be omitted. When undefined, the round-robin behaviour of REQ-015 applies.

Structure
REQ-028 The shared package SHALL hold the FSM state enum, MCB_INSTR_WRITE (3'b000) and MCB_BL_SINGLE (6'd0).
REQ-029 A combinational sub-module rr_arbiter2 (requests, pointer -> one-hot grant) is natural; everything else SHALL be flat.

Verification
REQ-030 req_0 with addr 0x100, data 0xDEADBEEF, mask 0x0 -> wr_en at cycle 1 with data 0xDEADBEEF; cmd_en at cycle 2 with addr 0x100, instr 0, bl 0; done_0 at cycle 2.
REQ-031 req_0 and req_1 raised together after reset -> requester 0 served first, then requester 1 (done_1 at cycle 5). With MEM_ARB_FIXED_PRIO_EN and req_0 held high, requester 1 is never served.
REQ-032 mem_wr_full held high for 5 cycles while in DATA -> wr_en stays 0 and asserts in the first cycle full is low; data is unchanged despite data_0 toggling.
REQ-033 mem_cmd_full high for 3 cycles in CMD -> cmd_en and done are delayed exactly 3 cycles.
REQ-034 addr_1 = 0x103 -> mem_cmd_byte_addr = 0x100.
REQ-035 rst asserted in CMD -> next cycle cmd_en=0, no done pulse, state IDLE, pointer=1.
